argmax_scanner: RTL and testbench
=================================

ARGMAX_SCANNER -- requirements
Module: argmax_scanner

Interface
Parameters (name, default, meaning):
REQ-001 NUM_CLASSES, 10, number of class scores scanned; legal range 2..16.
REQ-002 PROB_W, 16, width of each class score in bits.
REQ-003 SIGNED_CMP, 0, 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 MARGIN_TH, 16'h0400, minimum top-1 minus top-2 margin for Confident; PROB_W bits.
Ports (name, direction, width, meaning):
REQ-005 Clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 Reset_n  in  1  synchronous, active-low reset.
REQ-007 Start  in  1  request a scan; sampled only in IDLE.
REQ-008 Prob_in  in  NUM_CLASSES*PROB_W  class scores; class i at bits [i*PROB_W +: PROB_W].
REQ-009 Busy  out  1  high in SCAN and DONE.
REQ-010 Valid  out  1  one-cycle pulse; results are new and stable.
REQ-011 Argmax  out  4  index of the highest score.
REQ-012 Max_prob  out  PROB_W  highest score.
REQ-013 Second_idx  out  4  index of the second-highest score.
REQ-014 Margin  out  PROB_W  Max_prob minus second-highest score.
REQ-015 Confident  out  1  Margin >= MARGIN_TH.

Function
REQ-016 FSM states: IDLE, SCAN, DONE.
- IDLE->SCAN on Start=1.
- SCAN->DONE after class NUM_CLASSES-1 is processed.
- DONE->IDLE unconditionally after one cycle.
REQ-017 On Start accepted, the block snapshots all of Prob_in into an internal register and loads best = class 0.
- second-best is marked invalid.
- the index counter is set to 1.
- Prob_in changes after that edge have no effect on the running scan.
REQ-018 SCAN processes exactly one class per cycle, in ascending index order.
REQ-019 Update rule for candidate c with score p:
- if p > best: second := best, best := (c, p);
- else if second is invalid or p > second: second := (c, p).
REQ-020 Comparisons are strictly greater, so on ties the lowest index wins for both best and second.
REQ-021 Comparison is signed when SIGNED_CMP=1 and unsigned otherwise.
REQ-022 Valid is asserted exactly NUM_CLASSES-1 cycles after the cycle in which Start was sampled high, coincident with DONE, for exactly one cycle.
REQ-023 Argmax, Max_prob, Second_idx, Margin and Confident update only at the edge entering DONE.
- they hold their values until the next scan completes.
REQ-024 Start while Busy=1 (SCAN or DONE) is ignored; no queuing.
REQ-025 Start held high continuously produces back-to-back scans, each taking NUM_CLASSES+1 cycles from acceptance to the next acceptance.
REQ-026 Margin is computed at PROB_W bits; it is never negative because best >= second.
REQ-027 Index outputs are zero-extended to 4 bits.

Reset
REQ-028 Reset_n=0 at a rising edge forces:
- state = IDLE, Busy = 0, Valid = 0;
- Argmax = 0, Max_prob = 0, Second_idx = 0, Margin = 0, Confident = 0;
- the index counter and snapshot registers = 0.
REQ-029 Reset mid-scan aborts the scan; no Valid is produced and the previous results are cleared.
REQ-030 Reset has priority over Start in the same cycle.

Configuration
REQ-031 Macro ARGMAX_MARGIN_EN.
- When defined, Margin and Confident are computed per REQ-014, REQ-015 and REQ-026.
- When undefined, the margin subtractor and comparator are not synthesised; Margin reads constant 0 and Confident reads constant 1 after reset deassertion.
- Argmax, Max_prob and Second_idx behave identically in both builds.

Verification
REQ-032 Default parameters; scores 10,20,...,100 for classes 0..9; pulse Start.
- Valid occurs 9 cycles later.
- Argmax=9, Max_prob=100, Second_idx=8, Margin=10, Confident=0.
REQ-033 Scores all 16'h0500 except class 3 = 16'h0A00.
- Argmax=3, Second_idx=0 (tie resolves to lowest index), Margin=16'h0500, Confident=1.
REQ-034 SIGNED_CMP=1; class 0 = 16'hFFFF, class 5 = 16'h0001, all other classes 16'h8000.
- Argmax=5, Second_idx=0.
REQ-035 Start held high for 30 cycles.
- Valid pulses on cycles 9, 20 and 31 relative to the first accept.
- A Prob_in change during SCAN does not alter the in-flight result.
REQ-036 Reset_n=0 driven 4 cycles into a scan.
- No Valid pulse occurs.
- All outputs read 0.
- A subsequent Start produces a correct result.
REQ-037 Build without ARGMAX_MARGIN_EN and rerun REQ-032.
- Margin=0, Confident=1.
- All other outputs are unchanged.

Source files
------------

// File: rtl/argmax_scanner.sv
// argmax_scanner: snapshots NUM_CLASSES scores and finds top-1/top-2 one class per cycle.
// Optional margin/confidence path is built only when ARGMAX_MARGIN_EN is defined.
module argmax_scanner #(
    parameter int unsigned       NUM_CLASSES = 10,
    parameter int unsigned       PROB_W      = 16,
    parameter int                SIGNED_CMP  = 0,
    parameter logic [PROB_W-1:0] MARGIN_TH   = 'h0400
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          Start,
    input  logic [NUM_CLASSES*PROB_W-1:0] Prob_in,
    output logic                          Busy,
    output logic                          Valid,
    output logic [3:0]                    Argmax,
    output logic [PROB_W-1:0]             Max_prob,
    output logic [3:0]                    Second_idx,
    output logic [PROB_W-1:0]             Margin,
    output logic                          Confident
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    state_t            state_q, state_d;
    logic [PROB_W-1:0] snap_q [NUM_CLASSES];
    logic [PROB_W-1:0] snap_d [NUM_CLASSES];
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        best_idx_q, best_idx_d;
    logic [3:0]        sec_idx_q, sec_idx_d;
    logic [PROB_W-1:0] best_val_q, best_val_d;
    logic [PROB_W-1:0] sec_val_q, sec_val_d;
    logic              sec_vld_q, sec_vld_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [3:0]        argmax_q, argmax_d;
    logic [3:0]        second_idx_q, second_idx_d;
    logic [PROB_W-1:0] max_prob_q, max_prob_d;
    logic              confident_q, confident_d;
    logic [PROB_W-1:0] cand;
`ifdef ARGMAX_MARGIN_EN
    logic [PROB_W-1:0] margin_q, margin_d;
`endif

    function automatic logic gt(input logic [PROB_W-1:0] a, input logic [PROB_W-1:0] b);
        if (SIGNED_CMP != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        idx_d        = idx_q;
        best_idx_d   = best_idx_q;
        best_val_d   = best_val_q;
        sec_idx_d    = sec_idx_q;
        sec_val_d    = sec_val_q;
        sec_vld_d    = sec_vld_q;
        busy_d       = busy_q;
        valid_d      = 1'b0;
        argmax_d     = argmax_q;
        max_prob_d   = max_prob_q;
        second_idx_d = second_idx_q;
`ifdef ARGMAX_MARGIN_EN
        margin_d     = margin_q;
        confident_d  = confident_q;
`else
        confident_d  = 1'b1;
`endif

        cand = '0;
        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            if (idx_q == 4'(i)) begin
                cand = snap_q[i];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                        snap_d[i] = Prob_in[i*PROB_W +: PROB_W];
                    end
                    best_idx_d = '0;
                    best_val_d = Prob_in[PROB_W-1:0];
                    sec_idx_d  = '0;
                    sec_val_d  = '0;
                    sec_vld_d  = 1'b0;
                    idx_d      = 4'd1;
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (gt(cand, best_val_q)) begin
                    sec_idx_d  = best_idx_q;
                    sec_val_d  = best_val_q;
                    sec_vld_d  = 1'b1;
                    best_idx_d = idx_q;
                    best_val_d = cand;
                end else if (!sec_vld_q || gt(cand, sec_val_q)) begin
                    sec_idx_d = idx_q;
                    sec_val_d = cand;
                    sec_vld_d = 1'b1;
                end
                idx_d = idx_q + 4'd1;
                // Results capture the post-update top-2 so the last class lands in the same edge.
                if (idx_q == LAST_IDX) begin
                    state_d      = DONE;
                    valid_d      = 1'b1;
                    argmax_d     = best_idx_d;
                    max_prob_d   = best_val_d;
                    second_idx_d = sec_idx_d;
`ifdef ARGMAX_MARGIN_EN
                    margin_d     = best_val_d - sec_val_d;
                    confident_d  = (margin_d >= MARGIN_TH);
`endif
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            snap_q       <= '{default: '0};
            idx_q        <= '0;
            best_idx_q   <= '0;
            best_val_q   <= '0;
            sec_idx_q    <= '0;
            sec_val_q    <= '0;
            sec_vld_q    <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            argmax_q     <= '0;
            max_prob_q   <= '0;
            second_idx_q <= '0;
            confident_q  <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            margin_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            best_idx_q   <= best_idx_d;
            best_val_q   <= best_val_d;
            sec_idx_q    <= sec_idx_d;
            sec_val_q    <= sec_val_d;
            sec_vld_q    <= sec_vld_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            argmax_q     <= argmax_d;
            max_prob_q   <= max_prob_d;
            second_idx_q <= second_idx_d;
            confident_q  <= confident_d;
`ifdef ARGMAX_MARGIN_EN
            margin_q     <= margin_d;
`endif
        end
    end

    assign Busy       = busy_q;
    assign Valid      = valid_q;
    assign Argmax     = argmax_q;
    assign Max_prob   = max_prob_q;
    assign Second_idx = second_idx_q;
    assign Confident  = confident_q;
`ifdef ARGMAX_MARGIN_EN
    assign Margin     = margin_q;
`else
    assign Margin     = '0;
`endif

endmodule

// File: tb/tb_argmax_scanner.sv
// Bench for argmax_scanner: unsigned and signed instances driven in parallel, checked
// against a whole-vector top-2 reference model.
module tb_argmax_scanner;

    localparam int N = 10;
    localparam int W = 16;
`ifdef ARGMAX_MARGIN_EN
    localparam bit MARGIN_EN = 1'b1;
`else
    localparam bit MARGIN_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]   bi;
        logic [3:0]   si;
        logic [W-1:0] bv;
        logic [W-1:0] margin;
        logic         conf;
    } res_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [N*W-1:0] prob_in = '0;

    logic         u_busy, u_valid, u_conf, s_busy, s_valid, s_conf;
    logic [3:0]   u_argmax, u_second, s_argmax, s_second;
    logic [W-1:0] u_max, u_margin, s_max, s_margin;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    argmax_scanner #(.NUM_CLASSES(N), .PROB_W(W), .SIGNED_CMP(0), .MARGIN_TH(16'h0400)) u_dut (
        .Clk(clk), .Reset_n(reset_n), .Start(start), .Prob_in(prob_in),
        .Busy(u_busy), .Valid(u_valid), .Argmax(u_argmax), .Max_prob(u_max),
        .Second_idx(u_second), .Margin(u_margin), .Confident(u_conf)
    );

    argmax_scanner #(.NUM_CLASSES(N), .PROB_W(W), .SIGNED_CMP(1), .MARGIN_TH(16'h0400)) u_dut_s (
        .Clk(clk), .Reset_n(reset_n), .Start(start), .Prob_in(prob_in),
        .Busy(s_busy), .Valid(s_valid), .Argmax(s_argmax), .Max_prob(s_max),
        .Second_idx(s_second), .Margin(s_margin), .Confident(s_conf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Top-1 = first index holding the maximum; top-2 = first index holding the maximum of the rest.
    function automatic res_t ref_model(input logic [N*W-1:0] p, input bit sgn);
        int           key [N];
        int           b;
        int           s;
        logic [W-1:0] v;
        res_t         r;
        for (int i = 0; i < N; i++) begin
            v = p[i*W +: W];
            key[i] = sgn ? int'($signed(v)) : int'(v);
        end
        b = 0;
        for (int i = 1; i < N; i++) if (key[i] > key[b]) b = i;
        s = -1;
        for (int i = 0; i < N; i++) begin
            if (i != b && (s < 0 || key[i] > key[s])) s = i;
        end
        r.bi     = 4'(b);
        r.si     = 4'(s);
        r.bv     = p[b*W +: W];
        r.margin = MARGIN_EN ? (p[b*W +: W] - p[s*W +: W]) : '0;
        r.conf   = MARGIN_EN ? (r.margin >= 16'h0400) : 1'b1;
        return r;
    endfunction

    function automatic logic [N*W-1:0] rand_vec(input int mode);
        logic [N*W-1:0] p;
        logic [W-1:0]   v;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: v = W'($urandom);
                1: v = W'($urandom_range(0, 3));
                default: begin
                    case ($urandom_range(0, 4))
                        0: v = 16'h0000;
                        1: v = 16'h0001;
                        2: v = 16'h7FFF;
                        3: v = 16'h8000;
                        default: v = 16'hFFFF;
                    endcase
                end
            endcase
            p[i*W +: W] = v;
        end
        return p;
    endfunction

    task automatic check_outputs(input res_t ru, input res_t rs);
        check("u_argmax", u_argmax, ru.bi);
        check("u_max", u_max, ru.bv);
        check("u_second", u_second, ru.si);
        check("u_margin", u_margin, ru.margin);
        check("u_conf", u_conf, ru.conf);
        check("s_argmax", s_argmax, rs.bi);
        check("s_max", s_max, rs.bv);
        check("s_second", s_second, rs.si);
        check("s_margin", s_margin, rs.margin);
        check("s_conf", s_conf, rs.conf);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, u_busy, 0);
        check({tag, "_valid"}, u_valid, 0);
        check({tag, "_argmax"}, u_argmax, 0);
        check({tag, "_max"}, u_max, 0);
        check({tag, "_second"}, u_second, 0);
        check({tag, "_margin"}, u_margin, 0);
        check({tag, "_conf"}, u_conf, 0);
        check({tag, "_s_busy"}, s_busy, 0);
        check({tag, "_s_argmax"}, s_argmax, 0);
        check({tag, "_s_max"}, s_max, 0);
    endtask

    // One scan: accept, scramble Prob_in, optionally poke Start mid-scan, check latency and results.
    task automatic run_scan(input logic [N*W-1:0] p, input bit mid_start);
        int   n;
        bit   got;
        res_t ru;
        res_t rs;
        prob_in = p;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("busy_acc", u_busy, 1);
        prob_in = rand_vec(0);
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            start = (mid_start && n == 3);
            tick;
            n++;
            if (u_valid) got = 1'b1;
        end
        start = 1'b0;
        check("latency", n, N - 1);
        check("s_valid", s_valid, 1);
        ru = ref_model(p, 1'b0);
        rs = ref_model(p, 1'b1);
        check_outputs(ru, rs);
        tick;
        check("valid_drop", u_valid, 0);
        check("busy_drop", u_busy, 0);
        check("hold_argmax", u_argmax, ru.bi);
        check("hold_second", s_second, rs.si);
        tick;
        check("no_requeue", u_busy, 0);
    endtask

    initial begin
        logic [N*W-1:0] p;
        logic [N*W-1:0] pv [64];
        int             vcyc[$];
        int             pulses;

        reset_n = 1'b0;
        repeat (3) tick;
        check_zero("rst");
        reset_n = 1'b1;
        tick;
        check("idle_conf", u_conf, MARGIN_EN ? 0 : 1);
        check("idle_margin", u_margin, 0);

        for (int i = 0; i < N; i++) p[i*W +: W] = W'(10 * (i + 1));
        run_scan(p, 1'b0);
        tick;
        check("ramp_argmax", u_argmax, 9);
        check("ramp_max", u_max, 100);
        check("ramp_second", u_second, 8);
        check("ramp_margin", u_margin, MARGIN_EN ? 10 : 0);
        check("ramp_conf", u_conf, MARGIN_EN ? 0 : 1);

        for (int i = 0; i < N; i++) p[i*W +: W] = 16'h0500;
        p[3*W +: W] = 16'h0A00;
        run_scan(p, 1'b0);
        check("tie_argmax", u_argmax, 3);
        check("tie_second", u_second, 0);
        check("tie_margin", u_margin, MARGIN_EN ? 16'h0500 : 0);
        check("tie_conf", u_conf, 1);

        for (int i = 0; i < N; i++) p[i*W +: W] = 16'h8000;
        p[0*W +: W] = 16'hFFFF;
        p[5*W +: W] = 16'h0001;
        run_scan(p, 1'b1);
        check("sgn_argmax", s_argmax, 5);
        check("sgn_second", s_second, 0);
        check("uns_argmax", u_argmax, 0);
        check("uns_second", u_second, 1);

        for (int c = 0; c < 45; c++) begin
            prob_in = rand_vec(0);
            pv[c] = prob_in;
            start = (c < 30);
            tick;
            if (u_valid) begin
                vcyc.push_back(c);
                if (c >= N - 1) check_outputs(ref_model(pv[c-N+1], 1'b0), ref_model(pv[c-N+1], 1'b1));
            end
        end
        start = 1'b0;
        check("b2b_pulses", vcyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("b2b_cycle", (vcyc.size() > i) ? vcyc[i] : -1, 9 + 11 * i);
        end

        prob_in = rand_vec(0);
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        reset_n = 1'b0;
        tick;
        check_zero("midrst");
        tick;
        reset_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            tick;
            if (u_valid || s_valid) pulses++;
        end
        check("midrst_no_valid", pulses, 0);
        check("midrst_argmax", u_argmax, 0);
        run_scan(rand_vec(0), 1'b0);

        for (int k = 0; k < 24; k++) begin
            run_scan(rand_vec(k % 3), (k % 4) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
